rx_ordered_set: RTL and testbench

//  1000BASE-X PCS receive path (clause-36 style), the counterpart of the TX ordered-set/code-group logic.

---
 rtl/rx_ordered_set.sv | 262 ++++++++++++++++++++++++++
 tb/tb_rx_ordered_set.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ordered_set.sv
// 1000BASE-X PCS receive: 8b/10b decode, /S/../T/R/ frame delimiting, GMII-style RXD/RX_DV/RX_ER.
// Define RX_STATS_EN to add saturating frame and errored-frame counters.
module rx_ordered_set #(
    parameter logic [7:0] FC_CODE = 8'h0E
`ifdef RX_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync_status,
    input  logic [9:0] rx_code_group,
    output logic [7:0] RXD,
    output logic       RX_DV,
    output logic       RX_ER,
    output logic       receiving,
    output logic       rx_even
`ifdef RX_STATS_EN
    ,
    output logic [CNT_W-1:0] rx_pkt_count,
    output logic [CNT_W-1:0] rx_err_count
`endif
);

    localparam logic [7:0] K28_5_08B = 8'hBC;
    localparam logic [7:0] S_08B     = 8'hFB;
    localparam logic [7:0] T_08B     = 8'hFD;
    localparam logic [7:0] R_08B     = 8'hF7;
    localparam logic [7:0] V_08B     = 8'hFE;

    typedef struct packed {
        logic       valid;
        logic       k;
        logic [7:0] data;
    } cg_t;

    typedef enum logic [7:0] {
        LINK_FAILED     = 8'b0000_0001,
        WAIT_FOR_K      = 8'b0000_0010,
        RX_K            = 8'b0000_0100,
        IDLE_D          = 8'b0000_1000,
        FALSE_CARRIER   = 8'b0001_0000,
        START_OF_PACKET = 8'b0010_0000,
        RECEIVE         = 8'b0100_0000,
        TRI_RRI         = 8'b1000_0000
    } state_t;

    // Code-group bit 9 is 'a', bit 0 is 'j'. Returns {ok, EDCBA}.
    function automatic logic [5:0] dec6(input logic [5:0] c);
        case (c)
            6'b100111, 6'b011000: return {1'b1, 5'd0};
            6'b011101, 6'b100010: return {1'b1, 5'd1};
            6'b101101, 6'b010010: return {1'b1, 5'd2};
            6'b110001:            return {1'b1, 5'd3};
            6'b110101, 6'b001010: return {1'b1, 5'd4};
            6'b101001:            return {1'b1, 5'd5};
            6'b011001:            return {1'b1, 5'd6};
            6'b111000, 6'b000111: return {1'b1, 5'd7};
            6'b111001, 6'b000110: return {1'b1, 5'd8};
            6'b100101:            return {1'b1, 5'd9};
            6'b010101:            return {1'b1, 5'd10};
            6'b110100:            return {1'b1, 5'd11};
            6'b001101:            return {1'b1, 5'd12};
            6'b101100:            return {1'b1, 5'd13};
            6'b011100:            return {1'b1, 5'd14};
            6'b010111, 6'b101000: return {1'b1, 5'd15};
            6'b011011, 6'b100100: return {1'b1, 5'd16};
            6'b100011:            return {1'b1, 5'd17};
            6'b010011:            return {1'b1, 5'd18};
            6'b110010:            return {1'b1, 5'd19};
            6'b001011:            return {1'b1, 5'd20};
            6'b101010:            return {1'b1, 5'd21};
            6'b011010:            return {1'b1, 5'd22};
            6'b111010, 6'b000101: return {1'b1, 5'd23};
            6'b110011, 6'b001100: return {1'b1, 5'd24};
            6'b100110:            return {1'b1, 5'd25};
            6'b010110:            return {1'b1, 5'd26};
            6'b110110, 6'b001001: return {1'b1, 5'd27};
            6'b001110:            return {1'b1, 5'd28};
            6'b101110, 6'b010001: return {1'b1, 5'd29};
            6'b011110, 6'b100001: return {1'b1, 5'd30};
            6'b101011, 6'b010100: return {1'b1, 5'd31};
            default:              return 6'd0;
        endcase
    endfunction

    // Returns {ok, HGF}; both alternate D.x.7 encodings are accepted since disparity is unchecked.
    function automatic logic [3:0] dec4(input logic [3:0] c);
        case (c)
            4'b1011, 4'b0100:                   return {1'b1, 3'd0};
            4'b1001:                            return {1'b1, 3'd1};
            4'b0101:                            return {1'b1, 3'd2};
            4'b1100, 4'b0011:                   return {1'b1, 3'd3};
            4'b1101, 4'b0010:                   return {1'b1, 3'd4};
            4'b1010:                            return {1'b1, 3'd5};
            4'b0110:                            return {1'b1, 3'd6};
            4'b1110, 4'b0001, 4'b0111, 4'b1000: return {1'b1, 3'd7};
            default:                            return 4'd0;
        endcase
    endfunction

    function automatic logic is_k(input cg_t c, input logic [7:0] b);
        return c.valid && c.k && (c.data == b);
    endfunction

    logic [5:0] d6;
    logic [3:0] d4;
    cg_t        dec;

    assign d6 = dec6(rx_code_group[9:4]);
    assign d4 = dec4(rx_code_group[3:0]);

    // NOTE: dec gets a full default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        dec = '0;
        case (rx_code_group)
            10'h0FA, 10'h305: dec = '{valid: 1'b1, k: 1'b1, data: K28_5_08B};
            10'h368, 10'h097: dec = '{valid: 1'b1, k: 1'b1, data: S_08B};
            10'h2E8, 10'h117: dec = '{valid: 1'b1, k: 1'b1, data: T_08B};
            10'h3A8, 10'h057: dec = '{valid: 1'b1, k: 1'b1, data: R_08B};
            10'h1E8, 10'h217: dec = '{valid: 1'b1, k: 1'b1, data: V_08B};
            default: begin
                if (d6[5] && d4[3]) dec = '{valid: 1'b1, k: 1'b0, data: {d4[2:0], d6[4:0]}};
            end
        endcase
    end

    cg_t sr0_q, sr1_q, sr2_q;

    // NOTE: the pipeline is reset to invalid so stale entries can never look like K28.5 or /T/R/.
    // NOTE: non-blocking assignments let sr0->sr1->sr2 shift as one register stage each.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr0_q <= '0;
            sr1_q <= '0;
            sr2_q <= '0;
        end else begin
            sr0_q <= dec;
            sr1_q <= sr0_q;
            sr2_q <= sr1_q;
        end
    end

    logic cur_k285, cur_s, cur_data, cur_idle_d, check_end;

    assign cur_k285   = is_k(sr2_q, K28_5_08B);
    assign cur_s      = is_k(sr2_q, S_08B);
    assign cur_data   = sr2_q.valid && !sr2_q.k;
    assign cur_idle_d = cur_data && (sr2_q.data == 8'hC5 || sr2_q.data == 8'h50);
    assign check_end  = is_k(sr2_q, T_08B) && is_k(sr1_q, R_08B) && is_k(sr0_q, K28_5_08B);

    state_t     state_q;
    logic [7:0] rxd_q;
    logic       dv_q, er_q, recv_q, even_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LINK_FAILED;
            rxd_q   <= 8'h00;
            dv_q    <= 1'b0;
            er_q    <= 1'b0;
            recv_q  <= 1'b0;
            even_q  <= 1'b0;
        end else if (!sync_status) begin
            state_q <= LINK_FAILED;
            dv_q    <= 1'b0;
            er_q    <= 1'b0;
            recv_q  <= 1'b0;
            even_q  <= ~even_q;
        end else begin
            dv_q   <= 1'b0;
            er_q   <= 1'b0;
            recv_q <= 1'b0;
            if (cur_k285 && (state_q inside {WAIT_FOR_K, IDLE_D, TRI_RRI, FALSE_CARRIER}))
                even_q <= 1'b1;
            else
                even_q <= ~even_q;
            case (state_q)
                LINK_FAILED: state_q <= WAIT_FOR_K;
                WAIT_FOR_K:  if (cur_k285) state_q <= RX_K;
                RX_K:        state_q <= cur_idle_d ? IDLE_D : WAIT_FOR_K;
                IDLE_D: begin
                    if (cur_k285) begin
                        state_q <= RX_K;
                    end else if (cur_s) begin
                        state_q <= START_OF_PACKET;
                        rxd_q   <= 8'h55;
                        dv_q    <= 1'b1;
                        recv_q  <= 1'b1;
                    end else begin
                        state_q <= FALSE_CARRIER;
                        rxd_q   <= FC_CODE;
                        er_q    <= 1'b1;
                    end
                end
                FALSE_CARRIER: begin
                    if (cur_k285) begin
                        state_q <= RX_K;
                    end else begin
                        rxd_q <= FC_CODE;
                        er_q  <= 1'b1;
                    end
                end
                START_OF_PACKET, RECEIVE: begin
                    if (check_end) begin
                        state_q <= TRI_RRI;
                    end else if (cur_k285) begin
                        state_q <= RX_K;
                        er_q    <= 1'b1;
                    end else begin
                        state_q <= RECEIVE;
                        rxd_q   <= sr2_q.data;
                        dv_q    <= 1'b1;
                        recv_q  <= 1'b1;
                        er_q    <= !cur_data;
                    end
                end
                TRI_RRI:     if (cur_k285) state_q <= RX_K;
                default:     state_q <= LINK_FAILED;
            endcase
        end
    end

    assign RXD       = rxd_q;
    assign RX_DV     = dv_q;
    assign RX_ER     = er_q;
    assign receiving = recv_q;
    assign rx_even   = even_q;

`ifdef RX_STATS_EN
    logic             in_frame, sop_entry, tri_entry, early_end, frame_err;
    logic             err_seen_q;
    logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q;

    assign in_frame  = sync_status && (state_q == START_OF_PACKET || state_q == RECEIVE);
    assign sop_entry = sync_status && (state_q == IDLE_D) && cur_s;
    assign tri_entry = in_frame && check_end;
    assign early_end = in_frame && !check_end && cur_k285;
    assign frame_err = in_frame && !check_end && !cur_k285 && !cur_data;

    // An early end asserts RX_ER itself, so it always marks the frame as errored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_seen_q <= 1'b0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (sop_entry)      err_seen_q <= 1'b0;
            else if (frame_err) err_seen_q <= 1'b1;
            if (tri_entry && pkt_cnt_q != '1)
                pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            if (((tri_entry && err_seen_q) || early_end) && err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign rx_pkt_count = pkt_cnt_q;
    assign rx_err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_rx_ordered_set.sv
// Directed bench for rx_ordered_set: table-driven frame/idle vectors plus sync-loss and async-reset sequences.
module tb_rx_ordered_set;

    localparam logic [9:0] K285 = 10'h0FA;
    localparam logic [9:0] D162 = 10'h245;
    localparam logic [9:0] D56  = 10'h296;
    localparam logic [9:0] D22  = 10'h2D5;
    localparam logic [9:0] D00  = 10'h274;
    localparam logic [9:0] D01  = 10'h1D4;
    localparam logic [9:0] D02  = 10'h2D4;
    localparam logic [9:0] D03  = 10'h31B;
    localparam logic [9:0] CS   = 10'h368;
    localparam logic [9:0] CT   = 10'h2E8;
    localparam logic [9:0] CR   = 10'h3A8;
    localparam logic [9:0] CV   = 10'h1E8;
    localparam logic [9:0] INV  = 10'h000;

    logic       clk = 1'b0;
    logic       reset;
    logic       sync_status;
    logic [9:0] rx_code_group;
    logic [7:0] RXD;
    logic       RX_DV, RX_ER, receiving, rx_even;
`ifdef RX_STATS_EN
    logic [15:0] pkt_cnt, err_cnt;
`endif

    rx_ordered_set #(.FC_CODE(8'h0E)) dut (
        .clk           (clk),
        .reset         (reset),
        .sync_status   (sync_status),
        .rx_code_group (rx_code_group),
        .RXD           (RXD),
        .RX_DV         (RX_DV),
        .RX_ER         (RX_ER),
        .receiving     (receiving),
        .rx_even       (rx_even)
`ifdef RX_STATS_EN
        ,
        .rx_pkt_count  (pkt_cnt),
        .rx_err_count  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Each row: the code-group sent, and the outputs produced when the FSM consumes it.
    typedef struct {
        int         seg;
        logic [9:0] cg;
        logic       dv;
        logic       er;
        logic [7:0] rxd;
        logic       even;
        logic       ce;
    } vec_t;

    vec_t vecs[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int seg, input logic [9:0] cg, input logic dv, input logic er,
                       input logic [7:0] rxd, input logic even, input logic ce);
        vec_t v;
        v.seg = seg; v.cg = cg; v.dv = dv; v.er = er; v.rxd = rxd; v.even = even; v.ce = ce;
        vecs.push_back(v);
    endtask

    // Outputs for a code-group driven at one falling edge are visible four falling edges later.
    task automatic run_seg(input int s);
        int idx[$];
        foreach (vecs[j]) if (vecs[j].seg == s) idx.push_back(j);
        for (int i = 0; i < idx.size() + 4; i++) begin
            @(negedge clk);
            if (i >= 4) begin
                vec_t v;
                v = vecs[idx[i-4]];
                check($sformatf("s%0d r%0d RX_DV", s, i - 4), 32'(RX_DV), 32'(v.dv));
                check($sformatf("s%0d r%0d RX_ER", s, i - 4), 32'(RX_ER), 32'(v.er));
                check($sformatf("s%0d r%0d RXD", s, i - 4), 32'(RXD), 32'(v.rxd));
                if (v.ce) check($sformatf("s%0d r%0d rx_even", s, i - 4), 32'(rx_even), 32'(v.even));
            end
            sync_status = 1'b1;
            if (i < idx.size()) rx_code_group = vecs[idx[i]].cg;
            else rx_code_group = ((i - idx.size()) % 2 == 0) ? K285 : D162;
        end
    endtask

    task automatic drive(input logic [9:0] cg);
        @(negedge clk);
        rx_code_group = cg;
    endtask

    task automatic start_frame;
        drive(CS);
        drive(D00);
        drive(D01);
        drive(D02);
        drive(D03);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // Segment 1: idles, clean frame, errored frame.
        add(1, K285, 0, 0, 8'h00, 1, 1); add(1, D162, 0, 0, 8'h00, 0, 1);
        add(1, K285, 0, 0, 8'h00, 1, 1); add(1, D162, 0, 0, 8'h00, 0, 1);
        add(1, K285, 0, 0, 8'h00, 1, 1); add(1, D162, 0, 0, 8'h00, 0, 1);
        add(1, CS,   1, 0, 8'h55, 1, 1); add(1, D00,  1, 0, 8'h00, 0, 1);
        add(1, D01,  1, 0, 8'h01, 1, 1); add(1, D02,  1, 0, 8'h02, 0, 1);
        add(1, D03,  1, 0, 8'h03, 1, 1); add(1, CT,   0, 0, 8'h03, 0, 1);
        add(1, CR,   0, 0, 8'h03, 1, 1); add(1, K285, 0, 0, 8'h03, 1, 1);
        add(1, D162, 0, 0, 8'h03, 0, 1);
        add(1, CS,   1, 0, 8'h55, 1, 1); add(1, D00,  1, 0, 8'h00, 0, 1);
        add(1, INV,  1, 1, 8'h00, 1, 1); add(1, D01,  1, 0, 8'h01, 0, 1);
        add(1, CV,   1, 1, 8'hFE, 1, 1); add(1, CT,   0, 0, 8'hFE, 0, 1);
        add(1, CR,   0, 0, 8'hFE, 1, 1); add(1, K285, 0, 0, 8'hFE, 1, 1);
        add(1, D162, 0, 0, 8'hFE, 0, 1);
        // Segment 2: false carrier, RX_K rejecting a non-idle data byte, early end.
        add(2, K285, 0, 0, 8'hFE, 1, 1); add(2, D162, 0, 0, 8'hFE, 0, 1);
        add(2, D22,  0, 1, 8'h0E, 1, 1); add(2, D00,  0, 1, 8'h0E, 0, 1);
        add(2, K285, 0, 0, 8'h0E, 1, 1); add(2, D56,  0, 0, 8'h0E, 0, 1);
        add(2, K285, 0, 0, 8'h0E, 1, 1); add(2, D00,  0, 0, 8'h0E, 0, 1);
        add(2, CS,   0, 0, 8'h0E, 1, 1); add(2, K285, 0, 0, 8'h0E, 1, 1);
        add(2, D162, 0, 0, 8'h0E, 0, 1);
        add(2, CS,   1, 0, 8'h55, 1, 1); add(2, D00,  1, 0, 8'h00, 0, 1);
        add(2, K285, 0, 1, 8'h00, 1, 1); add(2, D162, 0, 0, 8'h00, 0, 1);
        // Segment 3: recovery after sync loss.
        add(3, K285, 0, 0, 8'h00, 1, 1); add(3, D162, 0, 0, 8'h00, 0, 1);
        add(3, CS,   1, 0, 8'h55, 0, 0); add(3, D01,  1, 0, 8'h01, 0, 0);
        add(3, CT,   0, 0, 8'h01, 0, 0); add(3, CR,   0, 0, 8'h01, 0, 0);
        add(3, K285, 0, 0, 8'h01, 1, 1); add(3, D162, 0, 0, 8'h01, 0, 1);
        // Segment 4: after a mid-frame reset, /S/ is ignored until /K28.5/D16.2/ is seen.
        add(4, CS,   0, 0, 8'h00, 0, 0); add(4, D00,  0, 0, 8'h00, 0, 0);
        add(4, CS,   0, 0, 8'h00, 0, 0); add(4, K285, 0, 0, 8'h00, 1, 1);
        add(4, D162, 0, 0, 8'h00, 0, 1); add(4, CS,   1, 0, 8'h55, 0, 0);
        add(4, D01,  1, 0, 8'h01, 0, 0); add(4, CT,   0, 0, 8'h01, 0, 0);
        add(4, CR,   0, 0, 8'h01, 0, 0); add(4, K285, 0, 0, 8'h01, 1, 1);
        add(4, D162, 0, 0, 8'h01, 0, 1);

        reset         = 1'b1;
        sync_status   = 1'b0;
        rx_code_group = INV;
        @(negedge clk);
        check("reset RXD", 32'(RXD), 32'h00);
        check("reset RX_DV", 32'(RX_DV), 32'h0);
        check("reset RX_ER", 32'(RX_ER), 32'h0);
        check("reset receiving", 32'(receiving), 32'h0);
        check("reset rx_even", 32'(rx_even), 32'h0);
`ifdef RX_STATS_EN
        check("reset pkt_cnt", 32'(pkt_cnt), 32'h0);
        check("reset err_cnt", 32'(err_cnt), 32'h0);
`endif
        reset       = 1'b0;
        sync_status = 1'b1;

        run_seg(1);
`ifdef RX_STATS_EN
        check("seg1 pkt_cnt", 32'(pkt_cnt), 32'd2);
        check("seg1 err_cnt", 32'(err_cnt), 32'd1);
`endif
        run_seg(2);
`ifdef RX_STATS_EN
        check("seg2 pkt_cnt", 32'(pkt_cnt), 32'd2);
`endif

        // Sync loss in the middle of a frame.
        start_frame();
        check("presync RX_DV", 32'(RX_DV), 32'h1);
        check("presync RXD", 32'(RXD), 32'h55);
        check("presync receiving", 32'(receiving), 32'h1);
        @(negedge clk);
        sync_status   = 1'b0;
        rx_code_group = INV;
        @(negedge clk);
        check("synclost RX_DV", 32'(RX_DV), 32'h0);
        check("synclost RX_ER", 32'(RX_ER), 32'h0);
        check("synclost receiving", 32'(receiving), 32'h0);
        @(negedge clk);
        check("synclost hold RX_DV", 32'(RX_DV), 32'h0);
        run_seg(3);
`ifdef RX_STATS_EN
        check("seg3 pkt_cnt", 32'(pkt_cnt), 32'd3);
`endif

        // Asynchronous reset in the middle of a frame.
        start_frame();
        check("prereset RX_DV", 32'(RX_DV), 32'h1);
        check("prereset receiving", 32'(receiving), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async reset RXD", 32'(RXD), 32'h00);
        check("async reset RX_DV", 32'(RX_DV), 32'h0);
        check("async reset RX_ER", 32'(RX_ER), 32'h0);
        check("async reset receiving", 32'(receiving), 32'h0);
        check("async reset rx_even", 32'(rx_even), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        run_seg(4);
`ifdef RX_STATS_EN
        check("seg4 pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("seg4 err_cnt", 32'(err_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
